// File: rtl/shifter_pkg.sv
// ============================================================================
// Module : shifter_pkg
// Shared multiplier datapath constants: operand widths and shift-select codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shifter_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 2 * IN_W;

    localparam logic [1:0] SH_NONE   = 2'b00;
    localparam logic [1:0] SH_NIBBLE = 2'b01;
    localparam logic [1:0] SH_BYTE   = 2'b10;
    localparam logic [1:0] SH_RSVD   = 2'b11;

endpackage : shifter_pkg

`default_nettype wire

// File: rtl/shifter_core.sv
// ============================================================================
// Module : shifter_core
// Combinational zero-extend and left-shift by 0, IN_W/2 or IN_W.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shifter_core #(
    parameter  int IN_W  = shifter_pkg::IN_W,
    localparam int OUT_W = 2 * IN_W
) (
    input  logic [IN_W-1:0]  inp,
    input  logic [1:0]       shift_cntrl,
    output logic [OUT_W-1:0] shift_res
);

    import shifter_pkg::*;

    logic [OUT_W-1:0] w_ext;

    assign w_ext = {{IN_W{1'b0}}, inp};

    // The reserved code falls into the default arm so it behaves as no shift.
    always_comb begin
        shift_res = w_ext;
        case (shift_cntrl)
            SH_NIBBLE: shift_res = w_ext << (IN_W / 2);
            SH_BYTE:   shift_res = w_ext << IN_W;
            default:   shift_res = w_ext;
        endcase
    end

endmodule : shifter_core

`default_nettype wire

// File: rtl/shifter.sv
// ============================================================================
// Module : shifter
// Registered placement of a partial product into a double-width field.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shifter #(
    parameter  int IN_W  = shifter_pkg::IN_W,
    localparam int OUT_W = 2 * IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  inp,
    input  logic [1:0]       shift_cntrl,
    input  logic             in_valid,
    output logic [OUT_W-1:0] shift_out,
    output logic             out_valid
);

    import shifter_pkg::*;

    logic [OUT_W-1:0] w_shift_res;
    logic [OUT_W-1:0] r_shift_out;
    logic             r_out_valid;

    shifter_core #(
        .IN_W (IN_W)
    ) u_core (
        .inp         (inp),
        .shift_cntrl (shift_cntrl),
        .shift_res   (w_shift_res)
    );

    // Data only loads on valid, so an unknown select with in_valid low is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_shift_out <= w_shift_res;
            end
        end
    end

    assign shift_out = r_shift_out;
    assign out_valid = r_out_valid;

endmodule : shifter

`default_nettype wire

// File: tb/tb_shifter.sv
// ============================================================================
// Module : tb_shifter
// Directed and random checks of the registered shifter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_shifter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  inp;
    logic [1:0]  shift_cntrl;
    logic        in_valid;
    logic [15:0] shift_out;
    logic        out_valid;

    int n_tests;
    int n_fail;

    shifter u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inp         (inp),
        .shift_cntrl (shift_cntrl),
        .in_valid    (in_valid),
        .shift_out   (shift_out),
        .out_valid   (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at a falling edge; the next falling edge sees the result.
    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] sc);
        in_valid    = v;
        inp         = d;
        shift_cntrl = sc;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] d, input logic v);
        check({tag, "_data"},  shift_out, d);
        check({tag, "_valid"}, {15'd0, out_valid}, {15'd0, v});
    endtask

    logic [15:0] m_out;
    logic        m_valid;
    logic [15:0] m_next;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        inp         = 8'h00;
        shift_cntrl = 2'b00;

        // Asynchronous reset between edges must clear outputs at once.
        #2 rst_n = 1'b0;
        #1 expect_out("rst_async", 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        expect_out("rst_hold", 16'h0000, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 8'h5A, 2'b01);
        expect_out("rst_release", 16'h0000, 1'b0);

        drive(1'b1, 8'hAA, 2'b00); expect_out("sweep00", 16'h00AA, 1'b1);
        drive(1'b1, 8'hAA, 2'b01); expect_out("sweep01", 16'h0AA0, 1'b1);
        drive(1'b1, 8'hAA, 2'b10); expect_out("sweep10", 16'hAA00, 1'b1);
        drive(1'b1, 8'hAA, 2'b11); expect_out("sweep11", 16'h00AA, 1'b1);

        drive(1'b1, 8'hFF, 2'b10); expect_out("ff_byte",   16'hFF00, 1'b1);
        drive(1'b1, 8'hFF, 2'b01); expect_out("ff_nibble", 16'h0FF0, 1'b1);
        drive(1'b1, 8'hFF, 2'b11); expect_out("ff_rsvd",   16'h00FF, 1'b1);
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 8'h00, s[1:0]);
            expect_out("zero", 16'h0000, 1'b1);
        end

        drive(1'b1, 8'h81, 2'b01); expect_out("hold_load", 16'h0810, 1'b1);
        drive(1'b0, 8'h3C, 2'b10); expect_out("hold1", 16'h0810, 1'b0);
        drive(1'b0, 8'hC3, 2'bxx); expect_out("hold2", 16'h0810, 1'b0);
        drive(1'b0, 8'hFF, 2'b01); expect_out("hold3", 16'h0810, 1'b0);

        // Reset mid-stream discards the pending second result.
        drive(1'b1, 8'h12, 2'b10); expect_out("b2b_first", 16'h1200, 1'b1);
        in_valid    = 1'b1;
        inp         = 8'h34;
        shift_cntrl = 2'b01;
        #2 rst_n = 1'b0;
        #1 expect_out("midrst_async", 16'h0000, 1'b0);
        @(negedge clk);
        expect_out("midrst_held", 16'h0000, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        expect_out("midrst_idle", 16'h0000, 1'b0);
        drive(1'b1, 8'h34, 2'b01); expect_out("b2b_second", 16'h0340, 1'b1);
        drive(1'b1, 8'h12, 2'b10); expect_out("b2b_a", 16'h1200, 1'b1);
        drive(1'b1, 8'h34, 2'b01); expect_out("b2b_b", 16'h0340, 1'b1);

        m_out   = 16'h0340;
        m_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            inp         = 8'($urandom);
            shift_cntrl = 2'($urandom);
            case (shift_cntrl)
                2'b01:   m_next = {4'h0, inp, 4'h0};
                2'b10:   m_next = {inp, 8'h00};
                default: m_next = {8'h00, inp};
            endcase
            if (in_valid) m_out = m_next;
            m_valid = in_valid;
            @(negedge clk);
            expect_out("rand", m_out, m_valid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shifter

`default_nettype wire
